// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined RV32 core: opcodes, ALUOp encodings and
// the control bundle carried down the pipeline.
package cpu_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_ITYPE = 2'b11
   } alu_op_e;

   // alu_op is kept as raw bits so any encoding from the decoder passes through untouched.
   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       memto_reg;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t BUBBLE = '{
      valid:     1'b0,
      reg_write: 1'b0,
      memto_reg: 1'b0,
      mem_read:  1'b0,
      mem_write: 1'b0,
      alu_op:    ALUOP_ADD,
      alu_src:   1'b0,
      branch:    1'b0
   };

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check: a load in EX whose destination feeds the instruction in ID.
module hazard_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       Stall_o
);

   // RS2 is compared for every opcode; a spurious stall costs one cycle, a missed one corrupts data.
   assign Stall_o = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic             RegWrite_i,
   input  logic             MemtoReg_i,
   input  logic             MemRead_i,
   input  logic             MemWrite_i,
   input  logic [1:0]       ALUOp_i,
   input  logic             ALUSrc_i,
   input  logic             Branch_i,
   input  logic [XLEN-1:0]  RS1data_i,
   input  logic [XLEN-1:0]  RS2data_i,
   input  logic [XLEN-1:0]  Imm_i,
   input  logic [XLEN-1:0]  PC_i,
   input  logic [9:0]       funct_i,
   input  logic [4:0]       RS1addr_i,
   input  logic [4:0]       RS2addr_i,
   input  logic [4:0]       RDaddr_i,
   input  logic             Flush_i,
   output logic             Stall_o,
   output logic             valid_o,
   output logic             RegWrite_o,
   output logic             MemtoReg_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic [1:0]       ALUOp_o,
   output logic             ALUSrc_o,
   output logic             Branch_o,
   output logic [XLEN-1:0]  RS1data_o,
   output logic [XLEN-1:0]  RS2data_o,
   output logic [XLEN-1:0]  Imm_o,
   output logic [XLEN-1:0]  PC_o,
   output logic [9:0]       funct_o,
   output logic [4:0]       RS1addr_o,
   output logic [4:0]       RS2addr_o,
   output logic [4:0]       RDaddr_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   ctrl_t            ctrl_in;
   ctrl_t            ctrl_q;
   logic [XLEN-1:0]  rs1_data_q, rs2_data_q, imm_q, pc_q;
   logic [9:0]       funct_q;
   logic [4:0]       rs1_q, rs2_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             load_bubble;

   assign ctrl_in = '{
      valid:     valid_i,
      reg_write: RegWrite_i,
      memto_reg: MemtoReg_i,
      mem_read:  MemRead_i,
      mem_write: MemWrite_i,
      alu_op:    ALUOp_i,
      alu_src:   ALUSrc_i,
      branch:    Branch_i
   };

   hazard_detect u_hazard (
      .ex_valid    (ctrl_q.valid),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_valid    (valid_i),
      .id_rs1      (RS1addr_i),
      .id_rs2      (RS2addr_i),
      .Stall_o     (Stall_o)
   );

   // Flush and stall together still produce a single bubble.
   assign load_bubble = Flush_i | Stall_o;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_q     <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         funct_q    <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         ctrl_q     <= load_bubble ? BUBBLE : ctrl_in;
         rd_q       <= load_bubble ? 5'd0 : RDaddr_i;
         rs1_data_q <= RS1data_i;
         rs2_data_q <= RS2data_i;
         imm_q      <= Imm_i;
         pc_q       <= PC_i;
         funct_q    <= funct_i;
         rs1_q      <= RS1addr_i;
         rs2_q      <= RS2addr_i;
         if (load_bubble && (cnt_q != {CNT_W{1'b1}}))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign valid_o      = ctrl_q.valid;
   assign RegWrite_o   = ctrl_q.reg_write;
   assign MemtoReg_o   = ctrl_q.memto_reg;
   assign MemRead_o    = ctrl_q.mem_read;
   assign MemWrite_o   = ctrl_q.mem_write;
   assign ALUOp_o      = ctrl_q.alu_op;
   assign ALUSrc_o     = ctrl_q.alu_src;
   assign Branch_o     = ctrl_q.branch;
   assign RS1data_o    = rs1_data_q;
   assign RS2data_o    = rs2_data_q;
   assign Imm_o        = imm_q;
   assign PC_o         = pc_q;
   assign funct_o      = funct_q;
   assign RS1addr_o    = rs1_q;
   assign RS2addr_o    = rs2_q;
   assign RDaddr_o     = rd_q;
   assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected outputs are queued at drive time and
// compared after the clock edge that should produce them.
module tb_id_ex_stage;
   import cpu_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
   logic [1:0]       ALUOp_i;
   logic             ALUSrc_i, Branch_i;
   logic [XLEN-1:0]  RS1data_i, RS2data_i, Imm_i, PC_i;
   logic [9:0]       funct_i;
   logic [4:0]       RS1addr_i, RS2addr_i, RDaddr_i;
   logic             Flush_i;
   logic             Stall_o;
   logic             valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
   logic [1:0]       ALUOp_o;
   logic             ALUSrc_o, Branch_o;
   logic [XLEN-1:0]  RS1data_o, RS2data_o, Imm_o, PC_o;
   logic [9:0]       funct_o;
   logic [4:0]       RS1addr_o, RS2addr_o, RDaddr_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   always #5 clk_i = ~clk_i;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
      .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
      .MemWrite_i(MemWrite_i), .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i),
      .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
      .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
      .Flush_i(Flush_i), .Stall_o(Stall_o), .valid_o(valid_o),
      .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
      .MemWrite_o(MemWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o),
      .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .PC_o(PC_o),
      .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   typedef struct packed {
      ctrl_t            ctrl;
      logic [XLEN-1:0]  rs1_data, rs2_data, imm, pc;
      logic [9:0]       funct;
      logic [4:0]       rs1, rs2, rd;
      logic [CNT_W-1:0] cnt;
   } out_t;

   out_t sb_q[$];
   out_t model;
   logic last_stall;
   int   vectors = 0;
   int   miscompares = 0;

   localparam ctrl_t C_RTYPE = '{valid:1'b1, reg_write:1'b1, memto_reg:1'b0, mem_read:1'b0,
                                 mem_write:1'b0, alu_op:ALUOP_RTYPE, alu_src:1'b0, branch:1'b0};
   localparam ctrl_t C_LOAD  = '{valid:1'b1, reg_write:1'b1, memto_reg:1'b1, mem_read:1'b1,
                                 mem_write:1'b0, alu_op:ALUOP_ADD, alu_src:1'b1, branch:1'b0};
   localparam ctrl_t C_STORE = '{valid:1'b1, reg_write:1'b0, memto_reg:1'b0, mem_read:1'b0,
                                 mem_write:1'b1, alu_op:ALUOP_ADD, alu_src:1'b1, branch:1'b0};
   localparam ctrl_t C_BRNCH = '{valid:1'b1, reg_write:1'b0, memto_reg:1'b0, mem_read:1'b0,
                                 mem_write:1'b0, alu_op:ALUOP_SUB, alu_src:1'b0, branch:1'b1};
   localparam ctrl_t C_ITYPE = '{valid:1'b1, reg_write:1'b1, memto_reg:1'b0, mem_read:1'b0,
                                 mem_write:1'b0, alu_op:ALUOP_ITYPE, alu_src:1'b1, branch:1'b0};

   function automatic out_t dut_out();
      out_t o;
      o.ctrl = '{valid:valid_o, reg_write:RegWrite_o, memto_reg:MemtoReg_o, mem_read:MemRead_o,
                 mem_write:MemWrite_o, alu_op:ALUOp_o, alu_src:ALUSrc_o, branch:Branch_o};
      o.rs1_data = RS1data_o; o.rs2_data = RS2data_o; o.imm = Imm_o; o.pc = PC_o;
      o.funct = funct_o; o.rs1 = RS1addr_o; o.rs2 = RS2addr_o; o.rd = RDaddr_o;
      o.cnt = bubble_cnt_o;
      return o;
   endfunction

   task automatic drive(input ctrl_t c, input logic [4:0] rs1, rs2, rd,
                        input logic [XLEN-1:0] d1, d2, input logic flush);
      valid_i = c.valid; RegWrite_i = c.reg_write; MemtoReg_i = c.memto_reg;
      MemRead_i = c.mem_read; MemWrite_i = c.mem_write; ALUOp_i = c.alu_op;
      ALUSrc_i = c.alu_src; Branch_i = c.branch;
      RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd;
      RS1data_i = d1; RS2data_i = d2; Flush_i = flush;
      Imm_i = $urandom; PC_i = $urandom & 32'hFFFF_FFFC; funct_i = 10'($urandom_range(0, 1023));
   endtask

   // Called just after a falling edge with inputs driven; checks Stall_o, then the registered result.
   task automatic step(input string name);
      out_t e, got;
      logic exp_stall, bub;
      #1;
      exp_stall = valid_i & model.ctrl.valid & model.ctrl.mem_read & (model.rd != 5'd0) &
                  ((model.rd == RS1addr_i) | (model.rd == RS2addr_i));
      last_stall = Stall_o;
      vectors++;
      if (Stall_o !== exp_stall) begin
         miscompares++;
         $display("FAIL %s stall: got %b expected %b", name, Stall_o, exp_stall);
      end
      bub = Flush_i | exp_stall;
      e.ctrl = '{valid:valid_i, reg_write:RegWrite_i, memto_reg:MemtoReg_i, mem_read:MemRead_i,
                 mem_write:MemWrite_i, alu_op:ALUOp_i, alu_src:ALUSrc_i, branch:Branch_i};
      e.rs1_data = RS1data_i; e.rs2_data = RS2data_i; e.imm = Imm_i; e.pc = PC_i;
      e.funct = funct_i; e.rs1 = RS1addr_i; e.rs2 = RS2addr_i; e.rd = RDaddr_i;
      e.cnt = model.cnt;
      if (bub) begin
         e.ctrl = '0;
         e.rd   = 5'd0;
         if (model.cnt != {CNT_W{1'b1}}) e.cnt = model.cnt + CNT_W'(1);
      end
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      e   = sb_q.pop_front();
      got = dut_out();
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("FAIL %s outputs: got %h expected %h", name, got, e);
      end
      model = e;
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive(C_RTYPE, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
      #2;
      vectors++;
      if (dut_out() !== '0 || Stall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got %h stall %b expected all zero", dut_out(), Stall_o);
      end
      model = '0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_pass_through();
      drive(C_RTYPE, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1'b0);
      step("pass_add");
      vectors++;
      if (RegWrite_o !== 1'b1 || ALUOp_o !== ALUOP_RTYPE || RS1data_o !== 32'd5 ||
          RS2data_o !== 32'd7 || RDaddr_o !== 5'd3 || last_stall !== 1'b0) begin
         miscompares++;
         $display("FAIL pass_fields: got rw=%b op=%b d1=%0d d2=%0d rd=%0d st=%b expected 1 10 5 7 3 0",
                  RegWrite_o, ALUOp_o, RS1data_o, RS2data_o, RDaddr_o, last_stall);
      end
   endtask

   task automatic test_load_use();
      logic [CNT_W-1:0] c0;
      c0 = model.cnt;
      drive(C_LOAD, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 1'b0);
      step("lu_lw");
      drive(C_RTYPE, 5'd5, 5'd1, 5'd6, 32'h11, 32'h22, 1'b0);
      step("lu_stall");
      vectors++;
      if (last_stall !== 1'b1 || valid_o !== 1'b0 || RDaddr_o !== 5'd0) begin
         miscompares++;
         $display("FAIL lu_bubble: got st=%b v=%b rd=%0d expected 1 0 0", last_stall, valid_o, RDaddr_o);
      end
      step("lu_release");
      vectors++;
      if (last_stall !== 1'b0 || valid_o !== 1'b1 || RS1addr_o !== 5'd5 || RDaddr_o !== 5'd6 ||
          bubble_cnt_o !== c0 + CNT_W'(1)) begin
         miscompares++;
         $display("FAIL lu_add: got st=%b v=%b rs1=%0d rd=%0d cnt=%0d expected 0 1 5 6 %0d",
                  last_stall, valid_o, RS1addr_o, RDaddr_o, bubble_cnt_o, c0 + CNT_W'(1));
      end
   endtask

   task automatic test_x0_dest();
      logic [CNT_W-1:0] c0;
      c0 = model.cnt;
      drive(C_LOAD, 5'd2, 5'd0, 5'd0, 32'h200, 32'h0, 1'b0);
      step("x0_lw");
      drive(C_RTYPE, 5'd0, 5'd1, 5'd6, 32'h0, 32'h3, 1'b0);
      step("x0_add");
      vectors++;
      if (last_stall !== 1'b0 || valid_o !== 1'b1 || bubble_cnt_o !== c0) begin
         miscompares++;
         $display("FAIL x0_nostall: got st=%b v=%b cnt=%0d expected 0 1 %0d",
                  last_stall, valid_o, bubble_cnt_o, c0);
      end
   endtask

   task automatic test_flush_stall();
      logic [CNT_W-1:0] c0;
      drive(C_LOAD, 5'd3, 5'd0, 5'd7, 32'h300, 32'h0, 1'b0);
      step("fs_lw");
      c0 = model.cnt;
      drive(C_STORE, 5'd1, 5'd7, 5'd0, 32'h4, 32'h5, 1'b1);
      step("fs_both");
      vectors++;
      if (last_stall !== 1'b1 || valid_o !== 1'b0 || bubble_cnt_o !== c0 + CNT_W'(1)) begin
         miscompares++;
         $display("FAIL fs_once: got st=%b v=%b cnt=%0d expected 1 0 %0d",
                  last_stall, valid_o, bubble_cnt_o, c0 + CNT_W'(1));
      end
      drive(C_BRNCH, 5'd1, 5'd2, 5'd0, 32'h6, 32'h7, 1'b1);
      step("flush_only");
   endtask

   task automatic test_valid_low();
      ctrl_t c;
      drive(C_LOAD, 5'd4, 5'd0, 5'd9, 32'h400, 32'h0, 1'b0);
      step("vl_lw");
      c = C_RTYPE;
      c.valid = 1'b0;
      drive(c, 5'd9, 5'd9, 5'd10, 32'h8, 32'h9, 1'b0);
      step("vl_idle");
   endtask

   task automatic test_back_to_back();
      ctrl_t tbl[5];
      tbl[0] = C_ITYPE; tbl[1] = C_STORE; tbl[2] = C_BRNCH; tbl[3] = C_LOAD; tbl[4] = C_RTYPE;
      for (int i = 0; i < 20; i++) begin
         drive(tbl[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 7) == 0));
         step("b2b");
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(C_LOAD, 5'd1, 5'd0, 5'd8, 32'h500, 32'h0, 1'b0);
      step("rms_lw");
      drive(C_RTYPE, 5'd8, 5'd2, 5'd11, 32'h1, 32'h2, 1'b0);
      #1;
      vectors++;
      if (Stall_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rms_pre: got stall %b expected 1", Stall_o);
      end
      #1 rst_i = 1'b0;
      #1;
      vectors++;
      if (dut_out() !== '0 || Stall_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rms_async: got %h stall %b expected all zero", dut_out(), Stall_o);
      end
      sb_q.delete();
      model = '0;
      @(negedge clk_i);
      rst_i = 1'b1;
   endtask

   task automatic test_saturation();
      int n;
      n = int'(16'hFFFC) - int'(model.cnt);
      drive(C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1);
      repeat (n) @(posedge clk_i);
      @(negedge clk_i);
      vectors++;
      if (bubble_cnt_o !== 16'hFFFC) begin
         miscompares++;
         $display("FAIL sat_preload: got %h expected fffc", bubble_cnt_o);
      end
      model = dut_out();
      model.cnt = 16'hFFFC;
      for (int i = 0; i < 3; i++) begin
         drive(C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1);
         step("sat_flush");
      end
      vectors++;
      if (bubble_cnt_o !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_top: got %h expected ffff", bubble_cnt_o);
      end
      drive(C_LOAD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1'b1);
      step("sat_hold");
      vectors++;
      if (bubble_cnt_o !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL sat_nowrap: got %h expected ffff", bubble_cnt_o);
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_load_use();
      test_x0_dest();
      test_flush_stall();
      test_valid_low();
      test_back_to_back();
      test_reset_mid_stall();
      test_pass_through();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage for the pipelined RV32 core.
- Captures the decode outputs each cycle: the main-control signal set plus register data, immediate, funct bits and register addresses.
- Presents them registered to the EX stage (ALU_Control, ALU, forwarding).
- Contains the load-use hazard check; on a hazard or branch flush it inserts a bubble in place of the decoded instruction.

Parameters:
- XLEN, 32, datapath width of register data, immediate and PC
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- valid_i  in  1  ID holds a real instruction
- RegWrite_i  in  1  control from main decoder
- MemtoReg_i  in  1  control from main decoder
- MemRead_i  in  1  control from main decoder
- MemWrite_i  in  1  control from main decoder
- ALUOp_i  in  2  control from main decoder
- ALUSrc_i  in  1  control from main decoder
- Branch_i  in  1  control from main decoder
- RS1data_i  in  XLEN  register file read port 1
- RS2data_i  in  XLEN  register file read port 2
- Imm_i  in  XLEN  sign-extended immediate
- PC_i  in  XLEN  instruction PC
- funct_i  in  10  {funct7, funct3}
- RS1addr_i  in  5  source register 1 index
- RS2addr_i  in  5  source register 2 index
- RDaddr_i  in  5  destination register index
- Flush_i  in  1  branch taken in EX; squash the ID instruction
- Stall_o  out  1  combinational; freeze PC and IF/ID this cycle
- valid_o  out  1  registered copy of valid_i
- RegWrite_o  out  1  registered copy of RegWrite_i
- MemtoReg_o  out  1  registered copy of MemtoReg_i
- MemRead_o  out  1  registered copy of MemRead_i
- MemWrite_o  out  1  registered copy of MemWrite_i
- ALUOp_o  out  2  registered copy of ALUOp_i
- ALUSrc_o  out  1  registered copy of ALUSrc_i
- Branch_o  out  1  registered copy of Branch_i
- RS1data_o  out  XLEN  registered copy of RS1data_i
- RS2data_o  out  XLEN  registered copy of RS2data_i
- Imm_o  out  XLEN  registered copy of Imm_i
- PC_o  out  XLEN  registered copy of PC_i
- funct_o  out  10  registered copy of funct_i
- RS1addr_o  out  5  registered copy of RS1addr_i
- RS2addr_o  out  5  registered copy of RS2addr_i
- RDaddr_o  out  5  registered copy of RDaddr_i
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_i low, asynchronous): every registered output is 0, including valid_o and bubble_cnt_o. Stall_o therefore evaluates to 0.
- Latency: 1 cycle. Inputs are sampled on the rising clk_i edge and appear at the outputs immediately after it.
- Hazard condition (combinational):
  - Stall_o = valid_i & valid_o & MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i)).
  - RS2 is compared for every opcode; this is deliberately conservative.
- Per-edge action, in priority order:
  1. Flush_i = 1: load a bubble. Stall_o is ignored.
  2. Stall_o = 1: load a bubble. The ID instruction stays in IF/ID, because the upstream stages freeze on Stall_o.
  3. Otherwise: load all *_i fields.
- Bubble contents: valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o, ALUSrc_o = 0; ALUOp_o = Add encoding (00); RDaddr_o = 0. Data and address fields other than RDaddr_o still load from the inputs; they are don't-care.
- A stall lasts exactly 1 cycle. The bubble has MemRead_o = 0, so the next cycle re-evaluates with no hazard and the held instruction proceeds.
- Flush and stall in the same cycle: a single bubble is inserted and counted once.
- valid_i = 0: fields load normally and produce no stall. The load is not counted as a bubble.
- bubble_cnt_o: increments by 1 on each edge that loads a bubble (flush or stall). It saturates at all-ones and does not wrap.
- Control outputs are stored exactly as received. There is no recombination; ALUOp encodings pass through unchanged.
- Reset asserted mid-stall: outputs clear immediately and Stall_o drops in the same cycle.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp encodings (Add, Subtract, RType, IType)
  - a packed struct for the 9-bit control bundle
  - the BUBBLE control constant
- One sub-module, hazard_detect: purely combinational, inputs EX-side MemRead/RDaddr/valid and ID-side RS1addr/RS2addr/valid, output Stall_o.

Test Plan:
- Reset: assert rst_i low mid-operation -> all outputs 0 asynchronously, before the next clock edge.
- Pass-through: R-type add x3,x1,x2 (RS1data=5, RS2data=7) -> next cycle RegWrite_o=1, ALUOp_o=RType, RS1data_o=5, RS2data_o=7, RDaddr_o=3, Stall_o=0.
- Load-use: lw x5 followed by add x6,x5,x1 -> Stall_o=1 for exactly 1 cycle, then a bubble (valid_o=0, RDaddr_o=0), then the add with RS1addr_o=5; bubble_cnt_o=1.
- x0 destination: lw x0 followed by add x6,x0,x1 -> Stall_o stays 0 and no bubble is inserted.
- Flush and stall together: load-use hazard with Flush_i=1 in the same cycle -> one bubble, bubble_cnt_o increments by exactly 1.
- Saturation: preload bubble_cnt_o near 16'hFFFF and force 3 flushes -> bubble_cnt_o reads 16'hFFFF and does not wrap to 0.
